// File: rtl/parser_arb_pkg.sv
// Shared types and defaults for the parser ingress arbiter.
package parser_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_XFER = 2'd1,
    ST_PAD  = 2'd2
  } arb_state_e;

  localparam int DEF_MAX_HDR_BEATS = 4;
  localparam int DEF_PARSER_GAP    = 3;

  // Bits needed to hold a counter that runs 0..max_val inclusive.
  function automatic int cnt_width(input int max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

  localparam int BEAT_IDX_W = cnt_width(DEF_MAX_HDR_BEATS);
  localparam int GAP_CNT_W  = cnt_width(DEF_PARSER_GAP);

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first requesting port at or after rr_ptr.
module rr_arbiter #(
  parameter int  NUM_PORTS = 4,
  localparam int PW        = $clog2(NUM_PORTS)
) (
  input  logic [NUM_PORTS-1:0] req,
  input  logic [PW-1:0]        rr_ptr,
  output logic [PW-1:0]        gnt_idx,
  output logic                 gnt_vld
);

  logic [PW-1:0] cand;

  // Walk the ring from rr_ptr; NUM_PORTS is a power of 2 so the add wraps.
  always_comb begin
    gnt_vld = 1'b0;
    gnt_idx = '0;
    cand    = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      cand = rr_ptr + PW'(i);
      if (!gnt_vld && req[cand]) begin
        gnt_vld = 1'b1;
        gnt_idx = cand;
      end
    end
  end

endmodule

// File: rtl/parser_in_arbiter.sv
// Per-packet round-robin arbiter sharing one parser among the ingress ports.
// Full packets go to m_axis; the first header beats are copied to the parser.
//
// state | meaning
// IDLE  | no packet owned; grant when the parser gap has expired
// XFER  | forwarding granted port; copying header beats to prs_axis
// PAD   | single-beat packet: emit a zero pad beat so the parser sees two
module parser_in_arbiter
  import parser_arb_pkg::*;
#(
  parameter int  C_S_AXIS_DATA_WIDTH  = 256,
  parameter int  C_S_AXIS_TUSER_WIDTH = 128,
  parameter int  NUM_PORTS            = 4,
  parameter int  MAX_HDR_BEATS        = DEF_MAX_HDR_BEATS,
  parameter int  PARSER_GAP           = DEF_PARSER_GAP,
  localparam int DW                   = C_S_AXIS_DATA_WIDTH,
  localparam int UW                   = C_S_AXIS_TUSER_WIDTH,
  localparam int KW                   = C_S_AXIS_DATA_WIDTH / 8,
  localparam int PW                   = $clog2(NUM_PORTS)
) (
  input  logic                    axis_clk,
  input  logic                    aresetn,
  input  logic [NUM_PORTS*DW-1:0] s_axis_tdata,
  input  logic [NUM_PORTS*UW-1:0] s_axis_tuser,
  input  logic [NUM_PORTS*KW-1:0] s_axis_tkeep,
  input  logic [NUM_PORTS-1:0]    s_axis_tvalid,
  input  logic [NUM_PORTS-1:0]    s_axis_tlast,
  output logic [NUM_PORTS-1:0]    s_axis_tready,
  output logic [DW-1:0]           m_axis_tdata,
  output logic [UW-1:0]           m_axis_tuser,
  output logic [KW-1:0]           m_axis_tkeep,
  output logic                    m_axis_tvalid,
  output logic                    m_axis_tlast,
  input  logic                    m_axis_tready,
  output logic [DW-1:0]           prs_axis_tdata,
  output logic [UW-1:0]           prs_axis_tuser,
  output logic [KW-1:0]           prs_axis_tkeep,
  output logic                    prs_axis_tvalid,
  output logic                    prs_axis_tlast,
  output logic [PW-1:0]           grant_port
);

  localparam int            BW       = cnt_width(MAX_HDR_BEATS);
  localparam int            GW       = cnt_width(PARSER_GAP);
  localparam logic [BW-1:0] HDR_MAX  = BW'(MAX_HDR_BEATS);
  localparam logic [BW-1:0] HDR_LAST = BW'(MAX_HDR_BEATS - 1);
  localparam logic [GW-1:0] GAP_LOAD = GW'(PARSER_GAP);

  arb_state_e    state_q, state_d;
  logic [PW-1:0] grant_q, grant_d;
  logic [PW-1:0] rr_ptr_q, rr_ptr_d;
  logic [BW-1:0] beat_idx_q, beat_idx_d;
  logic [GW-1:0] gap_cnt_q, gap_cnt_d;

  logic          prs_tvalid_q, prs_tvalid_d;
  logic          prs_tlast_q, prs_tlast_d;
  logic [DW-1:0] prs_tdata_q, prs_tdata_d;
  logic [UW-1:0] prs_tuser_q, prs_tuser_d;
  logic [KW-1:0] prs_tkeep_q, prs_tkeep_d;

  logic [PW-1:0] arb_gnt_idx;
  logic          arb_gnt_vld;

  logic [DW-1:0] sel_tdata;
  logic [UW-1:0] sel_tuser;
  logic [KW-1:0] sel_tkeep;
  logic          sel_tvalid;
  logic          sel_tlast;
  logic          hs;
  logic          prs_final;

  rr_arbiter #(.NUM_PORTS(NUM_PORTS)) u_rr_arbiter (
    .req     (s_axis_tvalid),
    .rr_ptr  (rr_ptr_q),
    .gnt_idx (arb_gnt_idx),
    .gnt_vld (arb_gnt_vld)
  );

  // Select the granted port's stream.
  always_comb begin
    sel_tdata  = '0;
    sel_tuser  = '0;
    sel_tkeep  = '0;
    sel_tvalid = 1'b0;
    sel_tlast  = 1'b0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (grant_q == PW'(i)) begin
        sel_tdata  = s_axis_tdata[i*DW +: DW];
        sel_tuser  = s_axis_tuser[i*UW +: UW];
        sel_tkeep  = s_axis_tkeep[i*KW +: KW];
        sel_tvalid = s_axis_tvalid[i];
        sel_tlast  = s_axis_tlast[i];
      end
    end
  end

  // Packet path is a pass-through of the granted port, only while in XFER.
  always_comb begin
    m_axis_tdata  = '0;
    m_axis_tuser  = '0;
    m_axis_tkeep  = '0;
    m_axis_tvalid = 1'b0;
    m_axis_tlast  = 1'b0;
    s_axis_tready = '0;
    if (state_q == ST_XFER) begin
      m_axis_tdata           = sel_tdata;
      m_axis_tuser           = sel_tuser;
      m_axis_tkeep           = sel_tkeep;
      m_axis_tvalid          = sel_tvalid;
      m_axis_tlast           = sel_tlast;
      s_axis_tready[grant_q] = m_axis_tready;
    end
  end

  assign hs        = m_axis_tvalid & m_axis_tready;
  assign prs_final = prs_tvalid_q & prs_tlast_q;

  // Next state, grant bookkeeping and the parser copy stage.
  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    rr_ptr_d     = rr_ptr_q;
    beat_idx_d   = beat_idx_q;
    prs_tvalid_d = 1'b0;
    prs_tlast_d  = 1'b0;
    prs_tdata_d  = '0;
    prs_tuser_d  = '0;
    prs_tkeep_d  = '0;
    unique case (state_q)
      ST_IDLE: begin
        // A final parser beat on the output this cycle has not yet loaded
        // gap_cnt, so it must block the grant as well.
        if (arb_gnt_vld && (gap_cnt_q == '0) && !prs_final) begin
          grant_d    = arb_gnt_idx;
          rr_ptr_d   = arb_gnt_idx + PW'(1);
          beat_idx_d = '0;
          state_d    = ST_XFER;
        end
      end
      ST_XFER: begin
        if (hs) begin
          if (beat_idx_q < HDR_MAX) begin
            prs_tvalid_d = 1'b1;
            prs_tdata_d  = sel_tdata;
            prs_tuser_d  = sel_tuser;
            prs_tkeep_d  = sel_tkeep;
            prs_tlast_d  = sel_tlast | (beat_idx_q == HDR_LAST);
            beat_idx_d   = beat_idx_q + BW'(1);
          end
          if (sel_tlast) begin
            state_d = (beat_idx_q == '0) ? ST_PAD : ST_IDLE;
          end
        end
      end
      ST_PAD: begin
        // The only header beat is still in the prs register, so its tuser
        // is reused for the pad.
        prs_tvalid_d = 1'b1;
        prs_tlast_d  = 1'b1;
        prs_tuser_d  = prs_tuser_q;
        state_d      = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Parser recovery timer, free-running with respect to the FSM.
  always_comb begin
    gap_cnt_d = gap_cnt_q;
    if (prs_final) begin
      gap_cnt_d = GAP_LOAD;
    end else if (gap_cnt_q != '0) begin
      gap_cnt_d = gap_cnt_q - GW'(1);
    end
  end

  // State and datapath registers.
  always_ff @(posedge axis_clk or negedge aresetn) begin
    if (!aresetn) begin
      state_q      <= ST_IDLE;
      grant_q      <= '0;
      rr_ptr_q     <= '0;
      beat_idx_q   <= '0;
      gap_cnt_q    <= '0;
      prs_tvalid_q <= 1'b0;
      prs_tlast_q  <= 1'b0;
      prs_tdata_q  <= '0;
      prs_tuser_q  <= '0;
      prs_tkeep_q  <= '0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      rr_ptr_q     <= rr_ptr_d;
      beat_idx_q   <= beat_idx_d;
      gap_cnt_q    <= gap_cnt_d;
      prs_tvalid_q <= prs_tvalid_d;
      prs_tlast_q  <= prs_tlast_d;
      prs_tdata_q  <= prs_tdata_d;
      prs_tuser_q  <= prs_tuser_d;
      prs_tkeep_q  <= prs_tkeep_d;
    end
  end

  assign prs_axis_tvalid = prs_tvalid_q;
  assign prs_axis_tlast  = prs_tlast_q;
  assign prs_axis_tdata  = prs_tdata_q;
  assign prs_axis_tuser  = prs_tuser_q;
  assign prs_axis_tkeep  = prs_tkeep_q;
  assign grant_port      = grant_q;

endmodule

// File: tb/tb_parser_in_arbiter.sv
// Scoreboard bench for parser_in_arbiter.
module tb_parser_in_arbiter;

  localparam int DW = 256;
  localparam int UW = 128;
  localparam int KW = 32;
  localparam int NP = 4;
  localparam int PW = 2;

  logic              axis_clk = 1'b0;
  logic              aresetn  = 1'b0;
  logic [NP*DW-1:0]  s_axis_tdata;
  logic [NP*UW-1:0]  s_axis_tuser;
  logic [NP*KW-1:0]  s_axis_tkeep;
  logic [NP-1:0]     s_axis_tvalid;
  logic [NP-1:0]     s_axis_tlast;
  logic [NP-1:0]     s_axis_tready;
  logic [DW-1:0]     m_axis_tdata;
  logic [UW-1:0]     m_axis_tuser;
  logic [KW-1:0]     m_axis_tkeep;
  logic              m_axis_tvalid;
  logic              m_axis_tlast;
  logic              m_axis_tready;
  logic [DW-1:0]     prs_axis_tdata;
  logic [UW-1:0]     prs_axis_tuser;
  logic [KW-1:0]     prs_axis_tkeep;
  logic              prs_axis_tvalid;
  logic              prs_axis_tlast;
  logic [PW-1:0]     grant_port;

  typedef struct {
    logic [DW-1:0] data;
    logic [UW-1:0] user;
    logic [KW-1:0] keep;
    logic          last;
    int            port;
    logic          first;
  } beat_t;

  beat_t   src_q [NP][$];
  beat_t   exp_m [$];
  beat_t   exp_p [$];
  bit      rdy_q [$];
  beat_t   drv_b;
  beat_t   chk_e;
  logic [NP-1:0] pop_pend = '0;
  logic [NP-1:0] exp_oh;
  int      n_chk = 0;
  int      n_fail = 0;
  int      cyc = 0;
  int      last_final_cyc = 0;
  bit      have_final = 1'b0;

  parser_in_arbiter dut (
    .axis_clk        (axis_clk),
    .aresetn         (aresetn),
    .s_axis_tdata    (s_axis_tdata),
    .s_axis_tuser    (s_axis_tuser),
    .s_axis_tkeep    (s_axis_tkeep),
    .s_axis_tvalid   (s_axis_tvalid),
    .s_axis_tlast    (s_axis_tlast),
    .s_axis_tready   (s_axis_tready),
    .m_axis_tdata    (m_axis_tdata),
    .m_axis_tuser    (m_axis_tuser),
    .m_axis_tkeep    (m_axis_tkeep),
    .m_axis_tvalid   (m_axis_tvalid),
    .m_axis_tlast    (m_axis_tlast),
    .m_axis_tready   (m_axis_tready),
    .prs_axis_tdata  (prs_axis_tdata),
    .prs_axis_tuser  (prs_axis_tuser),
    .prs_axis_tkeep  (prs_axis_tkeep),
    .prs_axis_tvalid (prs_axis_tvalid),
    .prs_axis_tlast  (prs_axis_tlast),
    .grant_port      (grant_port)
  );

  always #5 axis_clk = ~axis_clk;

  always @(posedge axis_clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Queue a packet at a port and push what m_axis and prs_axis must show.
  task automatic send_pkt(input int port, input int nb);
    beat_t b;
    beat_t bp;
    for (int i = 0; i < nb; i++) begin
      b.data  = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
      b.user  = {$urandom, $urandom, $urandom, $urandom};
      b.keep  = $urandom;
      b.last  = (i == nb - 1);
      b.port  = port;
      b.first = (i == 0);
      src_q[port].push_back(b);
      exp_m.push_back(b);
      if (i < 4) begin
        bp      = b;
        bp.last = (i == nb - 1) || (i == 3);
        exp_p.push_back(bp);
      end
      if (nb == 1) begin
        bp       = b;
        bp.data  = '0;
        bp.keep  = '0;
        bp.last  = 1'b1;
        bp.first = 1'b0;
        exp_p.push_back(bp);
      end
    end
  endtask

  function automatic bit busy();
    bit r = (exp_m.size() > 0) || (exp_p.size() > 0);
    for (int p = 0; p < NP; p++) if (src_q[p].size() > 0) r = 1'b1;
    return r;
  endfunction

  task automatic wait_drain(input string tag);
    int n = 0;
    while (busy() && n < 400) begin
      @(posedge axis_clk);
      n++;
    end
    chk({tag, "_drain_timeout"}, 256'(n >= 400), 256'(0));
    repeat (8) @(posedge axis_clk);
    #2;
  endtask

  // Sources, ready pattern and output checking, all on the falling edge.
  initial begin
    for (int p = 0; p < NP; p++) begin
      s_axis_tdata[p*DW +: DW] = {8{$urandom}};
      s_axis_tuser[p*UW +: UW] = {4{$urandom}};
      s_axis_tkeep[p*KW +: KW] = $urandom;
    end
    s_axis_tvalid = '1;
    s_axis_tlast  = '1;
    m_axis_tready = 1'b1;
    forever begin
      @(negedge axis_clk);
      for (int p = 0; p < NP; p++)
        if (pop_pend[p] && src_q[p].size() > 0) void'(src_q[p].pop_front());
      pop_pend = '0;
      for (int p = 0; p < NP; p++) begin
        if (src_q[p].size() > 0) begin
          drv_b = src_q[p][0];
          s_axis_tdata[p*DW +: DW] = drv_b.data;
          s_axis_tuser[p*UW +: UW] = drv_b.user;
          s_axis_tkeep[p*KW +: KW] = drv_b.keep;
          s_axis_tvalid[p]         = 1'b1;
          s_axis_tlast[p]          = drv_b.last;
        end else begin
          s_axis_tvalid[p] = 1'b0;
          s_axis_tlast[p]  = 1'b0;
        end
      end
      m_axis_tready = (rdy_q.size() > 0) ? rdy_q.pop_front() : 1'b1;
      #1;
      if (aresetn) begin
        pop_pend = s_axis_tvalid & s_axis_tready;
        if (m_axis_tvalid && m_axis_tready) begin
          if (exp_m.size() == 0) begin
            chk("m_extra_beat", 256'(1), 256'(0));
          end else begin
            chk_e  = exp_m.pop_front();
            exp_oh = '0;
            exp_oh[chk_e.port] = 1'b1;
            chk("m_tdata", 256'(m_axis_tdata), 256'(chk_e.data));
            chk("m_tuser", 256'(m_axis_tuser), 256'(chk_e.user));
            chk("m_tkeep", 256'(m_axis_tkeep), 256'(chk_e.keep));
            chk("m_tlast", 256'(m_axis_tlast), 256'(chk_e.last));
            chk("grant_port", 256'(grant_port), 256'(chk_e.port));
            chk("s_tready", 256'(s_axis_tready), 256'(exp_oh));
          end
        end else if (m_axis_tvalid) begin
          chk("s_tready_stall", 256'(s_axis_tready), 256'(0));
        end
        if (prs_axis_tvalid) begin
          if (exp_p.size() == 0) begin
            chk("prs_extra_beat", 256'(1), 256'(0));
          end else begin
            chk_e = exp_p.pop_front();
            chk("prs_tdata", 256'(prs_axis_tdata), 256'(chk_e.data));
            chk("prs_tuser", 256'(prs_axis_tuser), 256'(chk_e.user));
            chk("prs_tkeep", 256'(prs_axis_tkeep), 256'(chk_e.keep));
            chk("prs_tlast", 256'(prs_axis_tlast), 256'(chk_e.last));
            if (chk_e.first && have_final)
              chk("prs_spacing_ge6", 256'((cyc - last_final_cyc) >= 6), 256'(1));
          end
          if (prs_axis_tlast) begin
            have_final     = 1'b1;
            last_final_cyc = cyc;
          end
        end
      end
    end
  end

  // Test sequence; acts 2 time units after the rising edge.
  initial begin
    int n;
    #3;
    chk("rst_m_tvalid", 256'(m_axis_tvalid), 256'(0));
    chk("rst_m_tdata", 256'(m_axis_tdata), 256'(0));
    chk("rst_prs_tvalid", 256'(prs_axis_tvalid), 256'(0));
    chk("rst_prs_tdata", 256'(prs_axis_tdata), 256'(0));
    chk("rst_s_tready", 256'(s_axis_tready), 256'(0));
    chk("rst_grant_port", 256'(grant_port), 256'(0));
    #20;
    @(posedge axis_clk); #2;
    aresetn = 1'b1;
    repeat (2) @(posedge axis_clk);
    #2;

    send_pkt(0, 2);
    wait_drain("two_beat");

    send_pkt(1, 1);
    wait_drain("one_beat_pad");

    send_pkt(2, 6);
    wait_drain("six_beat");

    for (int k = 0; k < 3; k++) begin
      send_pkt(0, 2);
      send_pkt(2, 2);
    end
    wait_drain("round_robin");

    rdy_q = {1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    send_pkt(3, 5);
    wait_drain("ready_toggle");

    send_pkt(1, 6);
    n = 0;
    while (exp_m.size() > 4 && n < 100) begin
      @(posedge axis_clk);
      n++;
    end
    chk("mid_pkt_wait_timeout", 256'(n >= 100), 256'(0));
    #2;
    aresetn = 1'b0;
    #1;
    chk("midrst_m_tvalid", 256'(m_axis_tvalid), 256'(0));
    chk("midrst_m_tdata", 256'(m_axis_tdata), 256'(0));
    chk("midrst_s_tready", 256'(s_axis_tready), 256'(0));
    chk("midrst_prs_tvalid", 256'(prs_axis_tvalid), 256'(0));
    chk("midrst_grant_port", 256'(grant_port), 256'(0));
    for (int p = 0; p < NP; p++) src_q[p].delete();
    exp_m.delete();
    exp_p.delete();
    pop_pend   = '0;
    have_final = 1'b0;
    repeat (2) @(posedge axis_clk);
    #2;
    aresetn = 1'b1;
    send_pkt(3, 3);
    n = 0;
    while (exp_m.size() == 3 && n < 3) begin
      @(posedge axis_clk);
      n++;
    end
    chk("post_rst_first_beat_fast", 256'(exp_m.size() < 3), 256'(1));
    wait_drain("post_reset");

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL watchdog_timeout got=running exp=finished");
    $fatal(1, "watchdog");
  end

endmodule
